// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks pc through instruction memory, pulses the opcode/operand
// register load enables and hands each complete instruction to execute over valid/ready.
module fetch_sequencer #(
    parameter int unsigned   AW       = 8,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [7:0]    HALT_OP  = 8'hFF,
    parameter int unsigned   OPND_BIT = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] iram_addr,
    input  logic [7:0]    iram_data,
    output logic          fetch,
    output logic          opnd_fetch,
    output logic          ins_valid,
    input  logic          ins_ready,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    output logic          halted,
    output logic [15:0]   ins_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F_ADDR,
        S_F_LOAD,
        S_O_ADDR,
        S_O_LOAD,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_next;
    logic [15:0]   r_count;
    logic          w_accept;

    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_accept   = 1'b0;
        fetch      = 1'b0;
        opnd_fetch = 1'b0;
        ins_valid  = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_F_ADDR;
            end
            S_F_ADDR: w_next = S_F_LOAD;
            S_F_LOAD: begin
                fetch     = 1'b1;
                w_pc_next = r_pc + AW'(1);
                // Halt opcode wins even though its operand bit is set.
                if (iram_data == HALT_OP)       w_next = S_HALT;
                else if (iram_data[OPND_BIT])   w_next = S_O_ADDR;
                else                            w_next = S_ISSUE;
            end
            S_O_ADDR: w_next = S_O_LOAD;
            S_O_LOAD: begin
                opnd_fetch = 1'b1;
                w_pc_next  = r_pc + AW'(1);
                w_next     = S_ISSUE;
            end
            S_ISSUE: begin
                ins_valid = 1'b1;
                if (ins_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_F_ADDR;
                    if (jump) w_pc_next = jump_addr;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_accept && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
        end
    end

    assign iram_addr = r_pc;
    assign ins_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (RESET_PC 0 and FF) checked every cycle against an
// event-timestamp model, plus directed scenarios with hand-computed expectations.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i [2];
    logic       ready_i [2];
    logic       jump_i  [2];
    logic [7:0] jaddr_i [2];
    logic [7:0] rd      [2];
    logic [7:0] mem     [2][256];

    logic [7:0]  addr0, addr1;
    logic        fetch0, fetch1, opnd0, opnd1, valid0, valid1, halt0, halt1;
    logic [15:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut0 (
        .clk(clk), .rst(rst), .start(start_i[0]), .iram_addr(addr0), .iram_data(rd[0]),
        .fetch(fetch0), .opnd_fetch(opnd0), .ins_valid(valid0), .ins_ready(ready_i[0]),
        .jump(jump_i[0]), .jump_addr(jaddr_i[0]), .halted(halt0), .ins_count(cnt0)
    );

    fetch_sequencer #(.RESET_PC(8'hFF)) dut1 (
        .clk(clk), .rst(rst), .start(start_i[1]), .iram_addr(addr1), .iram_data(rd[1]),
        .fetch(fetch1), .opnd_fetch(opnd1), .ins_valid(valid1), .ins_ready(ready_i[1]),
        .jump(jump_i[1]), .jump_addr(jaddr_i[1]), .halted(halt1), .ins_count(cnt1)
    );

    // Synchronous-read instruction memories: data valid one cycle after the address.
    always @(posedge clk) begin
        rd[0] <= mem[0][addr0];
        rd[1] <= mem[1][addr1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: tracks pc/count/halt and the cycle numbers at which fetch, operand fetch and
    // valid are due, derived from the start/accept cycle plus the documented latencies.
    int          cyc = 0;
    logic [7:0]  m_pc    [2];
    logic [15:0] m_cnt   [2];
    bit          m_idle  [2];
    bit          m_halt  [2];
    bit          m_valid [2];
    int          t_f     [2];
    int          t_o     [2];
    int          t_v     [2];
    logic [7:0]  m_op;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_pc[i]    = (i == 0) ? 8'h00 : 8'hFF;
                m_cnt[i]   = 16'h0000;
                m_idle[i]  = 1'b1;
                m_halt[i]  = 1'b0;
                m_valid[i] = 1'b0;
                t_f[i]     = -1;
                t_o[i]     = -1;
                t_v[i]     = -1;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_idle[i] && start_i[i]) begin
                    m_idle[i] = 1'b0;
                    t_f[i]    = cyc + 2;
                end
                if (cyc == t_f[i]) begin
                    m_op    = mem[i][m_pc[i]];
                    m_pc[i] = m_pc[i] + 8'd1;
                    if (m_op == 8'hFF) m_halt[i] = 1'b1;
                    else if (m_op[7]) begin
                        t_o[i] = cyc + 2;
                        t_v[i] = cyc + 3;
                    end else t_v[i] = cyc + 1;
                end
                if (cyc == t_o[i]) m_pc[i] = m_pc[i] + 8'd1;
                if (m_valid[i] && ready_i[i]) begin
                    if (m_cnt[i] != 16'hFFFF) m_cnt[i] = m_cnt[i] + 16'd1;
                    if (jump_i[i]) m_pc[i] = jaddr_i[i];
                    m_valid[i] = 1'b0;
                    t_f[i]     = cyc + 2;
                end
            end
            cyc++;
            for (int i = 0; i < 2; i++)
                if (cyc == t_v[i]) m_valid[i] = 1'b1;
        end
    end

    task automatic cmp(input int i, input logic [7:0] a, input logic f, input logic o,
                       input logic v, input logic h, input logic [15:0] c);
        check($sformatf("m%0d iram_addr", i), 32'(a), 32'(m_pc[i]));
        check($sformatf("m%0d fetch", i),     32'(f), 32'(cyc == t_f[i]));
        check($sformatf("m%0d opnd_fetch", i), 32'(o), 32'(cyc == t_o[i]));
        check($sformatf("m%0d ins_valid", i), 32'(v), 32'(m_valid[i]));
        check($sformatf("m%0d halted", i),    32'(h), 32'(m_halt[i]));
        check($sformatf("m%0d ins_count", i), 32'(c), 32'(m_cnt[i]));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            cmp(0, addr0, fetch0, opnd0, valid0, halt0, cnt0);
            cmp(1, addr1, fetch1, opnd1, valid1, halt1, cnt1);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            ready_i[i] = 1'b0;
            jump_i[i]  = 1'b0;
            jaddr_i[i] = 8'h00;
        end
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 8'h00;
            mem[1][a] = 8'h00;
        end
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    logic [9:0] fv, vv, ov;
    logic [7:0] opv;
    int         nf;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            ready_i[i] = 1'b0;
            jump_i[i]  = 1'b0;
            jaddr_i[i] = 8'h00;
        end
        #1 rst = 1'b1;
        do_reset();
        check("reset iram_addr m0", 32'(addr0), 32'h00);
        check("reset iram_addr m1", 32'(addr1), 32'hFF);
        check("reset outputs m0", 32'({fetch0, opnd0, valid0, halt0}), 32'h0);

        // 1-byte instructions back to back.
        mem[0][0] = 8'h01; mem[0][1] = 8'h02; mem[0][2] = 8'hFF;
        ready_i[0] = 1'b1;
        start_i[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            fv[k] = fetch0;
            vv[k] = valid0;
            @(negedge clk);
            start_i[0] = 1'b0;
        end
        check("t1 fetch cycles", 32'(fv), 32'h124);
        check("t1 valid cycles", 32'(vv), 32'h048);
        check("t1 ins_count", 32'(cnt0), 32'd2);
        check("t1 halted", 32'(halt0), 32'd1);
        check("t1 pc", 32'(addr0), 32'h03);

        // 2-byte instruction.
        do_reset();
        mem[0][0] = 8'h85; mem[0][1] = 8'h3C; mem[0][2] = 8'hFF;
        ready_i[0] = 1'b1;
        start_i[0] = 1'b1;
        fv = '0; ov = '0; vv = '0; opv = 8'h00;
        for (int k = 0; k < 6; k++) begin
            fv[k] = fetch0;
            ov[k] = opnd0;
            vv[k] = valid0;
            if (opnd0) opv = rd[0];
            @(negedge clk);
            start_i[0] = 1'b0;
        end
        check("t2 fetch cycles", 32'(fv), 32'h004);
        check("t2 opnd cycles", 32'(ov), 32'h010);
        check("t2 valid cycles", 32'(vv), 32'h020);
        check("t2 operand byte", 32'(opv), 32'h3C);
        check("t2 pc", 32'(addr0), 32'h02);

        // Stall in ISSUE with jump asserted but no accept, then accept with jump.
        do_reset();
        mem[0][0] = 8'h01; mem[0][8'h40] = 8'h02; mem[0][8'h41] = 8'hFF;
        jump_i[0]  = 1'b1;
        jaddr_i[0] = 8'h40;
        start_i[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start_i[0] = 1'b0;
        end
        nf = 0;
        for (int k = 0; k < 10; k++) begin
            check("t3 valid held", 32'(valid0), 32'd1);
            check("t3 pc frozen", 32'(addr0), 32'h01);
            nf += int'(fetch0) + int'(opnd0);
            @(negedge clk);
        end
        check("t3 no fetch pulses", 32'(nf), 32'd0);
        check("t3 count unchanged", 32'(cnt0), 32'd0);
        ready_i[0] = 1'b1;
        @(negedge clk);
        jump_i[0] = 1'b0;
        check("t4 jump target", 32'(addr0), 32'h40);
        check("t4 valid dropped", 32'(valid0), 32'd0);
        repeat (6) @(negedge clk);
        check("t4 count", 32'(cnt0), 32'd2);
        check("t4 halted", 32'(halt0), 32'd1);
        check("t4 pc", 32'(addr0), 32'h42);

        // Halt at address 3, sticky against start, cleared by reset.
        do_reset();
        mem[0][0] = 8'h01; mem[0][1] = 8'h02; mem[0][2] = 8'h03; mem[0][3] = 8'hFF;
        ready_i[0] = 1'b1;
        start_i[0] = 1'b1;
        repeat (14) begin
            @(negedge clk);
            start_i[0] = 1'b0;
        end
        check("t5 halted", 32'(halt0), 32'd1);
        check("t5 pc", 32'(addr0), 32'h04);
        check("t5 count", 32'(cnt0), 32'd3);
        check("t5 no valid", 32'(valid0), 32'd0);
        start_i[0] = 1'b1;
        nf = 0;
        for (int k = 0; k < 6; k++) begin
            nf += int'(fetch0);
            @(negedge clk);
            if (k == 2) start_i[0] = 1'b0;
        end
        check("t5 start ignored", 32'(nf), 32'd0);
        check("t5 still halted", 32'(halt0), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5 reset pc", 32'(addr0), 32'h00);
        check("t5 reset halted", 32'(halt0), 32'd0);
        check("t5 reset count", 32'(cnt0), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        // RESET_PC=FF: opcode at FF, operand wraps to address 0.
        do_reset();
        mem[1][8'hFF] = 8'h85; mem[1][0] = 8'h3C; mem[1][1] = 8'hFF;
        ready_i[1] = 1'b1;
        start_i[1] = 1'b1;
        ov = '0; opv = 8'h00;
        for (int k = 0; k < 6; k++) begin
            ov[k] = opnd1;
            if (opnd1) opv = rd[1];
            @(negedge clk);
            start_i[1] = 1'b0;
        end
        check("t6 opnd cycles", 32'(ov), 32'h010);
        check("t6 wrapped operand", 32'(opv), 32'h3C);
        check("t6 pc", 32'(addr1), 32'h01);
        check("t6 count", 32'(cnt1), 32'd1);

        // Reset while waiting on the operand address.
        do_reset();
        mem[1][8'hFF] = 8'h85;
        start_i[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start_i[1] = 1'b0;
        end
        check("t6 o_addr pc", 32'(addr1), 32'h00);
        check("t6 o_addr quiet", 32'({fetch1, opnd1, valid1}), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("t6 mid reset pc", 32'(addr1), 32'hFF);
        check("t6 mid reset outputs", 32'({fetch1, opnd1, valid1, halt1}), 32'h0);
        check("t6 mid reset count", 32'(cnt1), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        nf = 0;
        repeat (5) begin
            @(negedge clk);
            nf += int'(fetch1) + int'(opnd1);
        end
        check("t6 idle after reset", 32'(nf), 32'd0);
        check("t6 idle pc", 32'(addr1), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
